// File: rtl/keynsham_uart_tx_arbiter_pkg.sv
// Shared definitions for the keynsham UART transmit arbiter.
// Optional build macro used by the top: KEYNSHAM_UART_ARB_LOCK_EN (per-requester message lock).
package keynsham_uart_tx_arbiter_pkg;

   // state         | meaning
   // ARB_IDLE       | no byte in flight; waiting for a request and an idle uart
   // ARB_ISSUE      | one-cycle write strobe to the uart, ack to the owner
   // ARB_WAIT_START | waiting for tx_busy to rise, bounded by START_TIMEOUT
   // ARB_WAIT_DONE  | uart is shifting the byte out; waiting for tx_busy to fall
   typedef enum logic [1:0] {
      ARB_IDLE       = 2'd0,
      ARB_ISSUE      = 2'd1,
      ARB_WAIT_START = 2'd2,
      ARB_WAIT_DONE  = 2'd3
   } arb_state_e;

   localparam int DEF_NUM_REQ       = 2;
   localparam int DEF_START_TIMEOUT = 4;

   // Index width for a requester count; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keynsham_uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request strictly after the pointer, wrapping.
import keynsham_uart_tx_arbiter_pkg::*;

module keynsham_rr_pick #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IW-1:0]      idx,
   output logic               valid
);

   // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the last-served requester is checked last.
   always_comb begin
      int cand;
      pick  = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!valid && req[cand]) begin
            valid      = 1'b1;
            idx        = IW'(cand);
            pick[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/keynsham_uart_tx_arbiter.sv
// Shares one uart transmitter byte interface between NUM_REQ producers, one byte per grant.
// Build macro: KEYNSHAM_UART_ARB_LOCK_EN adds req_lock, keeping a multi-byte message from one
// requester together; when undefined the arbiter is pure per-byte round-robin.
import keynsham_uart_tx_arbiter_pkg::*;

module keynsham_uart_tx_arbiter #(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]   req_lock,
`endif
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 uart_wr_en,
   output logic [7:0]           uart_din,
   input  logic                 uart_tx_busy,
   output logic                 start_err,
   output logic                 arb_busy
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [IW-1:0] PTR_RST  = IW'(NUM_REQ - 1);

   arb_state_e         state, state_nxt;
   logic [IW-1:0]      ptr;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] pick_oh, sel_oh;
   logic [IW-1:0]      pick_idx, sel_idx;
   logic               pick_vld;
   logic [7:0]         sel_byte;
   logic               load, finish, cnt_clr, cnt_inc;

   keynsham_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .pick  (pick_oh),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

`ifdef KEYNSHAM_UART_ARB_LOCK_EN
   logic          lock_vld;
   logic [IW-1:0] lock_idx;
   logic          lock_hit;

   assign lock_hit = lock_vld && req[lock_idx];
`endif

   // Winner selection: a held lock overrides rotation, then mux the winner's byte.
   always_comb begin
      sel_oh  = pick_oh;
      sel_idx = pick_idx;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
      if (lock_hit) begin
         sel_oh           = '0;
         sel_oh[lock_idx] = 1'b1;
         sel_idx          = lock_idx;
      end
`endif
      sel_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_oh[i]) sel_byte = req_data[8*i +: 8];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ARB_IDLE;
      else     state <= state_nxt;
   end

   // Next state and strobes; a lock hit implies some req is set, so pick_vld covers both paths.
   always_comb begin
      state_nxt  = state;
      load       = 1'b0;
      finish     = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      uart_wr_en = 1'b0;
      ack        = '0;
      start_err  = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (pick_vld && !uart_tx_busy) begin
               load      = 1'b1;
               state_nxt = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            uart_wr_en = 1'b1;
            ack        = grant;
            cnt_clr    = 1'b1;
            state_nxt  = ARB_WAIT_START;
         end
         ARB_WAIT_START: begin
            if (uart_tx_busy) begin
               state_nxt = ARB_WAIT_DONE;
            end else if (cnt == CNT_LAST) begin
               start_err = 1'b1;
               finish    = 1'b1;
               state_nxt = ARB_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ARB_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               finish    = 1'b1;
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   assign arb_busy = (state != ARB_IDLE);

   // Captured byte, owner, rotation pointer and start timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= PTR_RST;
         grant    <= '0;
         uart_din <= '0;
         cnt      <= '0;
      end else begin
         if (load) begin
            ptr      <= sel_idx;
            grant    <= sel_oh;
            uart_din <= sel_byte;
         end
         if (finish) grant <= '0;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CW'(1);
      end
   end

`ifdef KEYNSHAM_UART_ARB_LOCK_EN
   // Lock follows the owner's req_lock at byte completion; released once the owner goes quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_vld <= 1'b0;
         lock_idx <= '0;
      end else if (finish) begin
         lock_vld <= req_lock[ptr];
         lock_idx <= ptr;
      end else if (state == ARB_IDLE && lock_vld && !req[lock_idx]) begin
         lock_vld <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_keynsham_uart_tx_arbiter.sv
// Bench for keynsham_uart_tx_arbiter (two requesters); lock scenario built only with
// KEYNSHAM_UART_ARB_LOCK_EN defined.
module tb_keynsham_uart_tx_arbiter;

   localparam int NR = 2;
   localparam int ST = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req = '0;
   logic [15:0]   req_data = '0;
   logic          uart_tx_busy = 1'b0;
   logic [NR-1:0] ack, grant;
   logic          uart_wr_en, start_err, arb_busy;
   logic [7:0]    uart_din;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
   logic [NR-1:0] req_lock = '0;
`endif

   keynsham_uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(ST)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
      .req_lock     (req_lock),
`endif
      .ack          (ack),
      .grant        (grant),
      .uart_wr_en   (uart_wr_en),
      .uart_din     (uart_din),
      .uart_tx_busy (uart_tx_busy),
      .start_err    (start_err),
      .arb_busy     (arb_busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_err = 0;
   bit model_auto = 1'b0;
   int tx_len = 3;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input int idx, input logic [7:0] d);
      exp_t e;
      e.idx  = idx;
      e.data = d;
      sbq.push_back(e);
   endtask

   // Scoreboard: every write strobe must match the oldest expected byte and its owner.
   initial begin
      forever begin
         @(negedge clk);
         if (start_err) n_err++;
         if (uart_wr_en) begin
            chk("sb_pending", 32'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
               exp_t e;
               e = sbq.pop_front();
               chk("din", 32'(uart_din), 32'(e.data));
               chk("ack", 32'(ack), 32'(1) << e.idx);
               chk("grant", 32'(grant), 32'(1) << e.idx);
            end
         end else begin
            chk("ack_quiet", 32'(ack), 0);
         end
      end
   end

   // Uart core model: busy rises the cycle after the write strobe and stays tx_len cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_wr_en && model_auto) begin
            @(posedge clk);
            #1 uart_tx_busy = 1'b1;
            repeat (tx_len) @(posedge clk);
            #1 uart_tx_busy = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return ack[0];
         1:       return ack[1];
         2:       return uart_tx_busy;
         default: return start_err;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int which, input logic lvl, input int budget,
                           output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (sig(which) !== lvl && cycles < budget);
      chk(tag, 32'(sig(which)), 32'(lvl));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((arb_busy || uart_tx_busy) && n < budget);
      chk(tag, 32'(arb_busy), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Requesters hold req until they have received their quota of acks.
   task automatic run_reqs(input logic [1:0] mask, input int q0, input int q1, input int lock_n,
                           input int budget);
      int c0, c1, n;
      c0 = 0;
      c1 = 0;
      n  = 0;
      req = mask;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (ack[0]) begin
            c0++;
            if (c0 == q0) req[0] = 1'b0;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
            if (c0 == lock_n) req_lock[0] = 1'b0;
`endif
         end
         if (ack[1]) begin
            c1++;
            if (c1 == q1) req[1] = 1'b0;
         end
         if (req == '0 && !arb_busy && !uart_tx_busy) break;
      end
      chk("run_done", 32'(n < budget), 1);
      if (lock_n < 0) chk("lock_n", 32'(lock_n), 0);
   endtask

   initial begin
      int c;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_wr_en", 32'(uart_wr_en), 0);
      chk("rst_din", 32'(uart_din), 0);
      chk("rst_start_err", 32'(start_err), 0);
      chk("rst_arb_busy", 32'(arb_busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: single byte, busy held 10 cycles
      model_auto = 1'b1;
      tx_len = 10;
      req_data = 16'h0041;
      push_exp(0, 8'h41);
      req = 2'b01;
      wait_sig("t1_ack", 0, 1'b1, 20, c);
      req = 2'b00;
      wait_sig("t1_busy_rise", 2, 1'b1, 5, c);
      wait_sig("t1_busy_fall", 2, 1'b0, 20, c);
      chk("t1_arb_busy_at_fall", 32'(arb_busy), 1);
      @(negedge clk);
      chk("t1_arb_busy_after", 32'(arb_busy), 0);
      chk("t1_grant_after", 32'(grant), 0);

      // 2: both requesting, strict alternation from requester 0
      tx_len = 3;
      do_reset();
      req_data = 16'h3130;
      push_exp(0, 8'h30);
      push_exp(1, 8'h31);
      push_exp(0, 8'h30);
      push_exp(1, 8'h31);
      run_reqs(2'b11, 2, 2, 0, 200);

      // 3: uart never starts -> start_err START_TIMEOUT cycles after issue, then next req served
      model_auto = 1'b0;
      req_data = 16'h6655;
      push_exp(0, 8'h55);
      req = 2'b01;
      wait_sig("t3_ack", 0, 1'b1, 20, c);
      req = 2'b00;
      wait_sig("t3_err", 3, 1'b1, 20, c);
      chk("t3_err_delay", 32'(c), 32'(ST));
      @(negedge clk);
      chk("t3_grant_cleared", 32'(grant), 0);
      chk("t3_idle", 32'(arb_busy), 0);
      model_auto = 1'b1;
      push_exp(1, 8'h66);
      run_reqs(2'b10, 0, 1, 0, 100);

      // 4: reset during WAIT_DONE with uart busy; pending req held off until busy falls
      model_auto = 1'b0;
      req_data = 16'h8877;
      push_exp(0, 8'h77);
      req = 2'b01;
      wait_sig("t4_ack", 0, 1'b1, 20, c);
      req = 2'b00;
      @(posedge clk);
      #1 uart_tx_busy = 1'b1;
      req[1] = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4_in_flight", 32'(arb_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_rst_grant", 32'(grant), 0);
      chk("t4_rst_arb_busy", 32'(arb_busy), 0);
      chk("t4_rst_wr_en", 32'(uart_wr_en), 0);
      chk("t4_rst_din", 32'(uart_din), 0);
      repeat (5) begin
         @(negedge clk);
         chk("t4_blocked", 32'(arb_busy), 0);
      end
      push_exp(1, 8'h88);
      model_auto = 1'b1;
      @(posedge clk);
      #1 uart_tx_busy = 1'b0;
      wait_sig("t4_ack1", 1, 1'b1, 10, c);
      req = 2'b00;
      wait_idle("t4_idle", 40);

      // 5: uart busy across reset release with req[1] pending
      model_auto = 1'b0;
      @(posedge clk);
      #1 uart_tx_busy = 1'b1;
      req_data = 16'h5A00;
      req = 2'b10;
      do_reset();
      repeat (6) begin
         @(negedge clk);
         chk("t5_blocked", 32'(arb_busy), 0);
      end
      push_exp(1, 8'h5A);
      model_auto = 1'b1;
      @(posedge clk);
      #1 uart_tx_busy = 1'b0;
      wait_sig("t5_ack1", 1, 1'b1, 10, c);
      req = 2'b00;
      wait_idle("t5_idle", 40);

`ifdef KEYNSHAM_UART_ARB_LOCK_EN
      // 6: requester 0 locks for three bytes, then alternation resumes
      do_reset();
      req_data = 16'h3130;
      req_lock = 2'b01;
      push_exp(0, 8'h30);
      push_exp(0, 8'h30);
      push_exp(0, 8'h30);
      push_exp(1, 8'h31);
      push_exp(0, 8'h30);
      push_exp(1, 8'h31);
      run_reqs(2'b11, 4, 2, 3, 400);
      req_lock = 2'b00;
`endif

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 0);
      chk("start_err_total", 32'(n_err), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
